// File: rtl/or1200_insn_trace.sv
// Retired-instruction tracker for the OR1200 writeback stage: legacy toggle,
// retired-instruction counter with threshold pulse, and a trace FIFO for the monitor.
module or1200_insn_trace #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FILTER_NOP = 1,
  parameter int unsigned SATURATE   = 0,
  parameter int unsigned TRACE_EN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_freeze,
  input  logic [31:0]      wb_insn,
  input  logic             except_flushpipe,
  input  logic             ex_dslot,
  input  logic             cnt_clr,
  input  logic             cnt_en,
  input  logic             thr_we,
  input  logic [CNT_W-1:0] thr_wdata,
  input  logic             trc_ready,
  output logic             insn,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_ovf,
  output logic             thr_hit,
  output logic             trc_valid,
  output logic [32:0]      trc_data,
  output logic [7:0]       trc_drop
);

  logic nop_class;
  logic nonnop;
  logic retire;

  assign nop_class = (wb_insn[31:26] == 6'h05) && wb_insn[16];
  assign nonnop    = !((FILTER_NOP != 0) && nop_class);
  // A flush always retires exactly once, even when it carries a delay slot.
  assign retire    = !wb_freeze &&
                     ((nonnop && !(except_flushpipe && ex_dslot)) || except_flushpipe);

  always_ff @(posedge clk) begin
    if (rst)
      insn <= 1'b0;
    else if (retire)
      insn <= ~insn;
  end

  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             hit_next;

  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    cnt_next = cnt;
    ovf_next = cnt_ovf;
    hit_next = 1'b0;
    if (cnt_clr) begin
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (retire && cnt_en) begin
      if (cnt == '1) begin
        ovf_next = 1'b1;
        // A held saturated value is not an increment, so it never pulses.
        if (SATURATE == 0) begin
          cnt_next = '0;
          hit_next = (thr == '0);
        end
      end else begin
        cnt_next = cnt_inc;
        hit_next = (cnt_inc == thr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      cnt_ovf <= 1'b0;
      thr_hit <= 1'b0;
      thr     <= '0;
    end else begin
      cnt     <= cnt_next;
      cnt_ovf <= ovf_next;
      thr_hit <= hit_next;
      if (thr_we)
        thr <= thr_wdata;
    end
  end

  generate
    if (TRACE_EN != 0) begin : g_trace
      localparam int unsigned AW = $clog2(FIFO_DEPTH);
      localparam logic [AW:0] PTR_ONE = 1;

      logic [32:0] mem [FIFO_DEPTH];
      logic [AW:0] wptr;
      logic [AW:0] rptr;
      logic        empty;
      logic        full;
      logic        pop;
      logic        push;
      logic        drop;

      assign empty = (wptr == rptr);
      assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      assign pop   = !empty && trc_ready;
      // A full FIFO still accepts when the head leaves in the same cycle.
      assign push  = retire && (!full || pop);
      assign drop  = retire && full && !pop;

      assign trc_valid = !empty;
      assign trc_data  = empty ? '0 : mem[rptr[AW-1:0]];

      always_ff @(posedge clk) begin
        if (push)
          mem[wptr[AW-1:0]] <= {except_flushpipe, wb_insn};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wptr     <= '0;
          rptr     <= '0;
          trc_drop <= '0;
        end else begin
          if (push)
            wptr <= wptr + PTR_ONE;
          if (pop)
            rptr <= rptr + PTR_ONE;
          if (drop && (trc_drop != 8'hFF))
            trc_drop <= trc_drop + 8'd1;
        end
      end
    end else begin : g_no_trace
      logic unused_trace;

      assign unused_trace = ^{trc_ready, wb_insn};
      assign trc_valid    = 1'b0;
      assign trc_data     = '0;
      assign trc_drop     = '0;
    end
  endgenerate

endmodule

// File: tb/tb_or1200_insn_trace.sv
// Directed bench for or1200_insn_trace: a 32-bit wrap DUT plus 4-bit wrap and
// saturate DUTs, all checked each cycle against a queue/integer reference model.
module tb_or1200_insn_trace;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_freeze = 1'b0;
  logic [31:0] wb_insn = 32'h15010000;
  logic        except_flushpipe = 1'b0;
  logic        ex_dslot = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        cnt_en = 1'b1;
  logic        thr_we = 1'b0;
  logic [31:0] thr_wdata = '0;
  logic        trc_ready = 1'b0;

  logic        insn_a, insn_w, insn_s;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_w, cnt_s;
  logic        ovf_a, ovf_w, ovf_s;
  logic        hit_a, hit_w, hit_s;
  logic        valid_a, valid_w, valid_s;
  logic [32:0] data_a, data_w, data_s;
  logic [7:0]  drop_a, drop_w, drop_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  or1200_insn_trace #(.CNT_W(32), .FIFO_DEPTH(DEPTH), .FILTER_NOP(1), .SATURATE(0), .TRACE_EN(1)) dut_a (
    .clk(clk), .rst(rst), .wb_freeze(wb_freeze), .wb_insn(wb_insn),
    .except_flushpipe(except_flushpipe), .ex_dslot(ex_dslot), .cnt_clr(cnt_clr),
    .cnt_en(cnt_en), .thr_we(thr_we), .thr_wdata(thr_wdata), .trc_ready(trc_ready),
    .insn(insn_a), .cnt(cnt_a), .cnt_ovf(ovf_a), .thr_hit(hit_a),
    .trc_valid(valid_a), .trc_data(data_a), .trc_drop(drop_a));

  or1200_insn_trace #(.CNT_W(4), .FIFO_DEPTH(DEPTH), .FILTER_NOP(1), .SATURATE(0), .TRACE_EN(1)) dut_w (
    .clk(clk), .rst(rst), .wb_freeze(wb_freeze), .wb_insn(wb_insn),
    .except_flushpipe(except_flushpipe), .ex_dslot(ex_dslot), .cnt_clr(cnt_clr),
    .cnt_en(cnt_en), .thr_we(thr_we), .thr_wdata(thr_wdata[3:0]), .trc_ready(trc_ready),
    .insn(insn_w), .cnt(cnt_w), .cnt_ovf(ovf_w), .thr_hit(hit_w),
    .trc_valid(valid_w), .trc_data(data_w), .trc_drop(drop_w));

  or1200_insn_trace #(.CNT_W(4), .FIFO_DEPTH(DEPTH), .FILTER_NOP(1), .SATURATE(1), .TRACE_EN(1)) dut_s (
    .clk(clk), .rst(rst), .wb_freeze(wb_freeze), .wb_insn(wb_insn),
    .except_flushpipe(except_flushpipe), .ex_dslot(ex_dslot), .cnt_clr(cnt_clr),
    .cnt_en(cnt_en), .thr_we(thr_we), .thr_wdata(thr_wdata[3:0]), .trc_ready(trc_ready),
    .insn(insn_s), .cnt(cnt_s), .cnt_ovf(ovf_s), .thr_hit(hit_s),
    .trc_valid(valid_s), .trc_data(data_s), .trc_drop(drop_s));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integers for the counters, a queue for the FIFO.
  int          w_of[3]   = '{32, 4, 4};
  bit          sat_of[3] = '{1'b0, 1'b0, 1'b1};
  bit          m_ok = 1'b0;
  bit          m_insn;
  longint unsigned m_cnt[3], m_thr[3], m_max;
  bit          m_ovf[3], m_hit[3];
  logic [32:0] m_q[$];
  int          m_drop;
  bit          m_nop, m_ev, m_pop;

  always @(posedge clk) begin
    m_nop = (wb_insn[31:26] == 6'h05) && wb_insn[16];
    m_ev  = !wb_freeze && (except_flushpipe || (!m_nop && !(except_flushpipe && ex_dslot)));
    if (rst) begin
      m_ok = 1'b1;
      m_insn = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_cnt[k] = 0; m_thr[k] = 0; m_ovf[k] = 1'b0; m_hit[k] = 1'b0;
      end
      m_q.delete();
      m_drop = 0;
    end else begin
      if (m_ev) m_insn = !m_insn;
      for (int k = 0; k < 3; k++) begin
        m_max = (64'd1 << w_of[k]) - 1;
        m_hit[k] = 1'b0;
        if (cnt_clr) begin
          m_cnt[k] = 0;
          m_ovf[k] = 1'b0;
        end else if (m_ev && cnt_en) begin
          if (m_cnt[k] == m_max) begin
            m_ovf[k] = 1'b1;
            if (!sat_of[k]) begin
              m_cnt[k] = 0;
              m_hit[k] = (m_thr[k] == 0);
            end
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
            m_hit[k] = (m_cnt[k] == m_thr[k]);
          end
        end
        if (thr_we) m_thr[k] = thr_wdata & m_max;
      end
      m_pop = (m_q.size() > 0) && trc_ready;
      if (m_pop) void'(m_q.pop_front());
      if (m_ev) begin
        if (m_q.size() < DEPTH) m_q.push_back({except_flushpipe, wb_insn});
        else if (m_drop < 255) m_drop++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("insn_a", insn_a, m_insn);
      chk("insn_w", insn_w, m_insn);
      chk("insn_s", insn_s, m_insn);
      chk("cnt_a", cnt_a, m_cnt[0]);
      chk("cnt_w", cnt_w, m_cnt[1]);
      chk("cnt_s", cnt_s, m_cnt[2]);
      chk("ovf_a", ovf_a, m_ovf[0]);
      chk("ovf_w", ovf_w, m_ovf[1]);
      chk("ovf_s", ovf_s, m_ovf[2]);
      chk("hit_a", hit_a, m_hit[0]);
      chk("hit_w", hit_w, m_hit[1]);
      chk("hit_s", hit_s, m_hit[2]);
      chk("trc_valid", valid_a, m_q.size() > 0);
      chk("trc_data", data_a, (m_q.size() > 0) ? m_q[0] : 33'd0);
      chk("trc_drop", drop_a, m_drop);
      chk("trc_valid_s", valid_s, m_q.size() > 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_insn", insn_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_drop", drop_a, 0);
    rst = 1'b0;

    // Three plain retirements streaming straight through the FIFO.
    wb_insn = 32'h9C210004;
    trc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_toggle", insn_a, (i % 2 == 0) ? 1 : 0);
      chk("seq_word", data_a, {1'b0, 32'h9C210004});
    end
    chk("seq_cnt", cnt_a, 3);

    // NOP is filtered; NOP with flush + delay slot retires once.
    wb_insn = 32'h15010000;
    tick();
    chk("nop_toggle", insn_a, 1);
    chk("nop_cnt", cnt_a, 3);
    chk("nop_valid", valid_a, 0);
    except_flushpipe = 1'b1;
    ex_dslot = 1'b1;
    tick();
    chk("flush_toggle", insn_a, 0);
    chk("flush_cnt", cnt_a, 4);
    chk("flush_word", data_a, {1'b1, 32'h15010000});
    ex_dslot = 1'b0;

    // Freeze suppresses everything.
    trc_ready = 1'b0;
    wb_freeze = 1'b1;
    wb_insn = 32'h9C210004;
    for (int i = 0; i < 5; i++) begin
      except_flushpipe = i[0];
      tick();
    end
    wb_freeze = 1'b0;
    except_flushpipe = 1'b0;
    wb_insn = 32'h15010000;
    chk("frz_toggle", insn_a, 0);
    chk("frz_cnt", cnt_a, 4);
    chk("frz_word", data_a, {1'b1, 32'h15010000});
    chk("frz_drop", drop_a, 0);
    trc_ready = 1'b1;
    tick();

    // 4-bit counters: 14 -> 15 (threshold) -> wrap / saturate.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt_w", cnt_w, 0);
    thr_we = 1'b1;
    thr_wdata = 32'd15;
    tick();
    thr_we = 1'b0;
    wb_insn = 32'h9C210004;
    repeat (14) tick();
    chk("pre_cnt_w", cnt_w, 14);
    chk("pre_hit_w", hit_w, 0);
    tick();
    chk("thr_cnt_w", cnt_w, 15);
    chk("thr_hit_w", hit_w, 1);
    chk("thr_hit_s", hit_s, 1);
    chk("thr_ovf_w", ovf_w, 0);
    tick();
    chk("wrap_cnt_w", cnt_w, 0);
    chk("wrap_ovf_w", ovf_w, 1);
    chk("wrap_hit_w", hit_w, 0);
    chk("sat_cnt_s", cnt_s, 15);
    chk("sat_ovf_s", ovf_s, 1);
    chk("sat_hit_s", hit_s, 0);
    wb_insn = 32'h15010000;
    tick();

    // Overfill the FIFO, then push while full with a simultaneous pop.
    trc_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wb_insn = 32'h10000000 + i;
      tick();
    end
    chk("full_drop", drop_a, 2);
    chk("full_head", data_a, {1'b0, 32'h10000000});
    trc_ready = 1'b1;
    wb_insn = 32'h10000006;
    tick();
    chk("fullpop_drop", drop_a, 2);
    chk("fullpop_head", data_a, {1'b0, 32'h10000001});
    wb_insn = 32'h15010000;
    tick();
    chk("drain1", data_a, {1'b0, 32'h10000002});
    tick();
    chk("drain2", data_a, {1'b0, 32'h10000003});
    tick();
    chk("drain3", data_a, {1'b0, 32'h10000006});
    tick();
    chk("drain_empty", valid_a, 0);

    // Reset mid-stream with three queued entries and cnt = 9.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    wb_insn = 32'h9C210004;
    repeat (6) tick();
    wb_insn = 32'h15010000;
    tick();
    trc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_insn = 32'h10000010 + i;
      tick();
    end
    wb_insn = 32'h15010000;
    chk("pre_rst_cnt", cnt_a, 9);
    chk("pre_rst_valid", valid_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_data", data_a, 0);
    chk("mid_rst_drop", drop_a, 0);
    chk("mid_rst_ovf_w", ovf_w, 0);
    trc_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_valid", valid_a, 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
